// File: rtl/mux_word_serializer_pkg.sv
// Purpose: shared widths, FSM state type and select start/end helpers for the word serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_word_serializer_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select index presented first / last within a word, by bit order.
  function automatic logic [SEL_W-1:0] first_sel(input bit msb_first);
    return msb_first ? SEL_W'(DATA_W - 1) : SEL_W'(0);
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(input bit msb_first);
    return msb_first ? SEL_W'(0) : SEL_W'(DATA_W - 1);
  endfunction

endpackage

// File: rtl/mux_word_serializer_if.sv
// Purpose: word-in / bit-out bundle between an upstream producer and the serializer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready handshake on the word side; the serial side has no backpressure.
// Signals: in_valid, in_data[7:0], in_ready, sel[2:0], ser_out, ser_valid, busy, done.
interface mux_word_serializer_if;
  import mux_word_serializer_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [SEL_W-1:0]  sel;
  logic              ser_out;
  logic              ser_valid;
  logic              busy;
  logic              done;

  // master: upstream driver / observer side
  modport master (
    output in_valid, in_data,
    input  in_ready, sel, ser_out, ser_valid, busy, done
  );

  // slave: the serializer itself
  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/mux_word_serializer_mux8to1.sv
// Purpose: 8:1 bit selector, y = d[sel].
// Latency: combinational.
// Backpressure: none.
// Ports: d[7:0] data word, sel[2:0] index, y selected bit.
module mux8to1
  import mux_word_serializer_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  assign y = d[sel];

endmodule

// File: rtl/mux_word_serializer.sv
// Purpose: captures an 8-bit word and streams it out one bit at a time through mux8to1.
// Latency: word accepted at edge N -> bit 0 on ser_out in cycle N+1; word lasts 8*CLKS_PER_BIT cycles.
// Backpressure: in_ready high in IDLE and in the final cycle of the last bit, allowing gapless back-to-back words.
// Ports: clk, rst_n (async active-low), bus (slave modport: word handshake in, sel/ser_out/ser_valid/busy/done out).
module mux_word_serializer
  import mux_word_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_word_serializer_if.slave bus
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [SEL_W-1:0] FIRST_SEL = first_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_SEL  = last_sel(MSB_FIRST);

  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  hold_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;

  logic               bit_end;
  logic               word_end;
  logic               ready_c;
  logic               shifting_c;
  logic               accept;
  logic               ser_bit;

  // Terminal count of the current bit, and of the last bit of the word.
  assign bit_end  = (cnt_q == CNT_LAST);
  assign word_end = (state_q == SHIFT) && bit_end && (sel_q == LAST_SEL);
  assign accept   = bus.in_valid && ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    shifting_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shifting_c = 1'b1;
        // Ready only in the very last cycle so a waiting word follows with no gap.
        ready_c    = word_end;
        if (word_end && !bus.in_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word hold register, select counter and bit-cycle counter.
  // sel is reloaded only on accept and otherwise parks at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      sel_q  <= FIRST_SEL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= word_end;
      if (accept) begin
        hold_q <= bus.in_data;
        sel_q  <= FIRST_SEL;
        cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        if (bit_end) begin
          cnt_q <= '0;
          if (sel_q != LAST_SEL) begin
            sel_q <= MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  mux8to1 u_mux (
    .d   (hold_q),
    .sel (sel_q),
    .y   (ser_bit)
  );

  assign bus.in_ready  = ready_c;
  assign bus.sel       = sel_q;
  assign bus.ser_out   = ser_bit;
  assign bus.ser_valid = shifting_c;
  assign bus.busy      = shifting_c;
  assign bus.done      = done_q;

endmodule

// File: doc/mux_word_serializer.md
Name: mux_word_serializer

Overview:
Upstream sequencing stage for the 8:1 mux. Accepts an 8-bit word through a valid/ready handshake and holds it. Steps the 3-bit select through all eight positions and presents the chosen bit as a serial stream with a valid strobe. The selection path is the existing mux8to1 block, driven from the captured word and an internal select counter.

Parameters:
CLKS_PER_BIT, 1, clock cycles each bit is held on ser_out (range 1..256).
MSB_FIRST, 0, 0 = sel counts 0→7 (d[0] first); 1 = sel counts 7→0.

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_data  input  8  word to serialize
in_ready  output  1  block can accept a word this cycle
sel  output  3  current mux select, driven from internal counter
ser_out  output  1  selected bit (mux8to1 output of held word at sel)
ser_valid  output  1  ser_out carries a live bit
busy  output  1  word in progress
done  output  1  one-cycle pulse after last bit of a word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hold register=8'h00, sel=0 (7 if MSB_FIRST), bit-cycle counter=0. Outputs: in_ready=1, ser_valid=0, busy=0, done=0, ser_out=hold[sel]=0.
- Accept = in_valid && in_ready, sampled at the rising edge.
- States:
  - IDLE: in_ready=1. On accept: capture in_data, set sel to the first index, clear the bit counter, go to SHIFT.
  - SHIFT: ser_valid=1, busy=1.
    - Bit counter counts 0..CLKS_PER_BIT-1.
    - At terminal count, sel advances by ±1 and the counter clears.
    - At terminal count of the last index (7, or 0 if MSB_FIRST), the word is complete.
- Latency: word accepted at edge N → first bit on ser_out during cycle N+1. Each bit is stable for exactly CLKS_PER_BIT cycles. A word occupies 8×CLKS_PER_BIT cycles.
- in_ready is 1 in IDLE. In SHIFT it is 1 only in the final cycle of the last bit; otherwise 0.
- Word complete with accept in the same cycle: capture the new word, reset sel and the counter, stay in SHIFT. There are zero gap cycles between words.
- Word complete without accept: go to IDLE; ser_valid and busy drop next cycle.
- done: registered, high for exactly one cycle following the final bit cycle of each word. With back-to-back words, done coincides with bit 0 of the next word.
- Once captured, the word is held: in_data changes and in_valid deassertion during SHIFT have no effect.
- sel never wraps within a word. It is reloaded only on accept. In IDLE it stays at its last value.
- Reset asserted mid-word: the word is discarded immediately, all outputs go to reset values, and no done pulse is produced.
- ser_out is combinational from registered hold and sel only, so it has no input-to-output combinational path.

Decomposition:
- Shared package holds:
  - DATA_W=8 and SEL_W=3 constants.
  - State enum {IDLE, SHIFT}.
  - FIRST_SEL / LAST_SEL helper constants derived from MSB_FIRST.
- One sub-module, mux8to1, instantiated with d=hold register, sel=counter and y=ser_out.
- The bit-cycle counter is $clog2(CLKS_PER_BIT) bits wide, minimum 1. It stays inline.

Test Plan:
1. Reset mid-word, then a single word. CLKS_PER_BIT=1, MSB_FIRST=0.
   - Pulse rst_n low during bit 3 of a word: outputs return to reset values immediately, no done.
   - Then accept 8'hA5: ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sel = 0..7; done high on cycle 9; in_ready=1 only in cycle 8 and afterwards.
2. MSB_FIRST=1, 8'hA5: sel = 7..0; ser_out = 1,0,1,0,0,1,0,1.
3. Back-to-back, in_valid held high with 8'hFF then 8'h00: 16 contiguous ser_valid cycles (eight 1s, then eight 0s); done pulses at cycle 9 (with the first 0) and at cycle 17.
4. CLKS_PER_BIT=3, 8'h81: each bit held 3 cycles (1 for 3, 0 for 18, 1 for 3); 24 ser_valid cycles total.
5. Input changed to 8'h00 during a transfer of 8'h3C: serialized bits stay 0,0,1,1,1,1,0,0.
6. in_valid pulsed while in_ready=0 mid-word: request ignored, current word unaffected; the held in_valid is accepted only in the final bit cycle.
